// File: rtl/program_loader_if.sv
// Byte-stream input and memory write port of the boot loader.
// The loader takes the slave side; the stream source / memory model takes the master side.
interface program_loader_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    logic                  inValid;
    logic [DATA_WIDTH-1:0] inData;
    logic                  inReady;
    logic                  memWrite;
    logic [ADDR_WIDTH-1:0] memAddress;
    logic [DATA_WIDTH-1:0] memData;

    modport master (
        output inValid,
        output inData,
        input  inReady,
        input  memWrite,
        input  memAddress,
        input  memData
    );

    modport slave (
        input  inValid,
        input  inData,
        output inReady,
        output memWrite,
        output memAddress,
        output memData
    );
endinterface

// File: rtl/program_loader.sv
// Framed boot loader: parses address/length/payload/checksum from a byte stream, writes the
// payload to CPU memory and releases the CPU from reset only after a verified frame.
module program_loader #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    program_loader_if.slave       bus,
    output logic                  cpuReset,
    output logic [ADDR_WIDTH-1:0] loadBase,
    output logic                  done,
    output logic                  error
);
    localparam int LEN_WIDTH  = 2 * DATA_WIDTH;
    localparam int IDLE_WIDTH = $clog2(TIMEOUT + 1);

    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]  LEN_ZERO  = {LEN_WIDTH{1'b0}};
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE   = LEN_WIDTH'(1);
    localparam logic [IDLE_WIDTH-1:0] IDLE_ZERO = {IDLE_WIDTH{1'b0}};
    localparam logic [IDLE_WIDTH-1:0] IDLE_ONE  = IDLE_WIDTH'(1);
    localparam logic [IDLE_WIDTH-1:0] IDLE_LAST = IDLE_WIDTH'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_ADDR_HI = 3'd0,
        S_ADDR_LO = 3'd1,
        S_LEN_HI  = 3'd2,
        S_LEN_LO  = 3'd3,
        S_DATA    = 3'd4,
        S_CHECK   = 3'd5,
        S_RUN     = 3'd6,
        S_ERROR   = 3'd7
    } state_t;

    // Frame is good when payload sum plus checksum byte wraps to zero.
    function automatic logic checksum_ok(input logic [DATA_WIDTH-1:0] sum,
                                         input logic [DATA_WIDTH-1:0] ck);
        logic [DATA_WIDTH-1:0] total;
        total = sum + ck;
        return (total == DATA_ZERO);
    endfunction

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [DATA_WIDTH-1:0]   addr_hi_r;
    logic [DATA_WIDTH-1:0]   len_hi_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [LEN_WIDTH-1:0]    count_r;
    logic [DATA_WIDTH-1:0]   sum_r;
    logic [IDLE_WIDTH-1:0]   idle_r;
    logic                    in_ready_r;
    logic                    mem_write_r;
    logic [ADDR_WIDTH-1:0]   mem_address_r;
    logic [DATA_WIDTH-1:0]   mem_data_r;
    logic [ADDR_WIDTH-1:0]   load_base_r;
    logic                    cpu_reset_r;
    logic                    done_r;
    logic                    error_r;
    logic                    accept_s;
    logic                    active_s;
    logic                    timeout_s;
    logic [LEN_WIDTH-1:0]    len_s;
    logic [ADDR_WIDTH-1:0]   start_addr_s;

    assign accept_s     = bus.inValid && in_ready_r;
    assign len_s        = {len_hi_r, bus.inData};
    assign start_addr_s = ADDR_WIDTH'({addr_hi_r, bus.inData});

    // Idle-timer qualification: the timer only guards an open frame, never the wait for a first byte.
    always_comb begin
        active_s  = 1'b0;
        timeout_s = 1'b0;
        if ((state_r != S_ADDR_HI) && (state_r != S_RUN) && (state_r != S_ERROR)) begin
            active_s = 1'b1;
        end else begin
            active_s = 1'b0;
        end
        if (active_s && !accept_s && (idle_r == IDLE_LAST)) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Next-state decode; an accept always wins over a timeout in the same cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_ADDR_HI: begin
                if (accept_s) state_nxt_s = S_ADDR_LO;
                else          state_nxt_s = S_ADDR_HI;
            end
            S_ADDR_LO: begin
                if (accept_s)       state_nxt_s = S_LEN_HI;
                else if (timeout_s) state_nxt_s = S_ERROR;
                else                state_nxt_s = S_ADDR_LO;
            end
            S_LEN_HI: begin
                if (accept_s)       state_nxt_s = S_LEN_LO;
                else if (timeout_s) state_nxt_s = S_ERROR;
                else                state_nxt_s = S_LEN_HI;
            end
            S_LEN_LO: begin
                if (accept_s)       state_nxt_s = (len_s == LEN_ZERO) ? S_CHECK : S_DATA;
                else if (timeout_s) state_nxt_s = S_ERROR;
                else                state_nxt_s = S_LEN_LO;
            end
            S_DATA: begin
                if (accept_s)       state_nxt_s = (count_r == LEN_ONE) ? S_CHECK : S_DATA;
                else if (timeout_s) state_nxt_s = S_ERROR;
                else                state_nxt_s = S_DATA;
            end
            S_CHECK: begin
                if (accept_s)       state_nxt_s = checksum_ok(sum_r, bus.inData) ? S_RUN : S_ERROR;
                else if (timeout_s) state_nxt_s = S_ERROR;
                else                state_nxt_s = S_CHECK;
            end
            S_RUN:   state_nxt_s = S_RUN;
            S_ERROR: state_nxt_s = S_ERROR;
            default: state_nxt_s = S_ERROR;
        endcase
    end

    // State, datapath and registered outputs; status outputs are decoded from the next state
    // so they change in the same cycle the state does.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= S_ADDR_HI;
            addr_hi_r     <= DATA_ZERO;
            len_hi_r      <= DATA_ZERO;
            addr_r        <= ADDR_ZERO;
            count_r       <= LEN_ZERO;
            sum_r         <= DATA_ZERO;
            idle_r        <= IDLE_ZERO;
            in_ready_r    <= 1'b1;
            mem_write_r   <= 1'b0;
            mem_address_r <= ADDR_ZERO;
            mem_data_r    <= DATA_ZERO;
            load_base_r   <= ADDR_ZERO;
            cpu_reset_r   <= 1'b1;
            done_r        <= 1'b0;
            error_r       <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s != S_RUN) && (state_nxt_s != S_ERROR);
            cpu_reset_r <= (state_nxt_s != S_RUN);
            done_r      <= (state_nxt_s == S_RUN);
            error_r     <= (state_nxt_s == S_ERROR);
            mem_write_r <= 1'b0;

            if (active_s && !accept_s) begin
                idle_r <= idle_r + IDLE_ONE;
            end else begin
                idle_r <= IDLE_ZERO;
            end

            if (accept_s) begin
                case (state_r)
                    S_ADDR_HI: addr_hi_r <= bus.inData;
                    S_ADDR_LO: begin
                        addr_r      <= start_addr_s;
                        load_base_r <= start_addr_s;
                    end
                    S_LEN_HI:  len_hi_r <= bus.inData;
                    S_LEN_LO:  count_r  <= len_s;
                    S_DATA: begin
                        mem_write_r   <= 1'b1;
                        mem_address_r <= addr_r;
                        mem_data_r    <= bus.inData;
                        addr_r        <= addr_r + ADDR_ONE;
                        sum_r         <= sum_r + bus.inData;
                        count_r       <= count_r - LEN_ONE;
                    end
                    default: begin
                    end
                endcase
            end else begin
            end
        end
    end

    assign bus.inReady    = in_ready_r;
    assign bus.memWrite   = mem_write_r;
    assign bus.memAddress = mem_address_r;
    assign bus.memData    = mem_data_r;
    assign cpuReset       = cpu_reset_r;
    assign loadBase       = load_base_r;
    assign done           = done_r;
    assign error          = error_r;
endmodule
